struct_member_packer: RTL

- Writer side of the packed-struct member part-select path.
- Accepts a byte stream and writes each byte into an indexed part-select of the payload member of a packed struct (payload[8*idx +: 8]).
- Stamps the tag member and presents the completed struct word through a single-entry valid/ready output buffer.
- Sits in front of any consumer that extracts fields or part-selects from the same struct type.

---
 rtl/struct_member_pkg.sv | 29 ++
 rtl/struct_member_byte_writer.sv | 28 ++
 rtl/struct_member_packer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/struct_member_pkg.sv
// Shared types for the packed-struct member packer path.
//   struct_word_t  : {tag, payload, par} at the default widths (TAG_W_D, NBYTES_D)
//   packer_state_e : writer FSM states
//   calc_par()     : even parity (XOR) over a zero-extended bit vector
package struct_member_pkg;

  localparam int unsigned TAG_W_D  = 2;
  localparam int unsigned NBYTES_D = 4;
  // Widest {tag, payload} that calc_par accepts; narrower inputs are zero-extended.
  localparam int unsigned ParMaxW  = 256;

  typedef struct packed {
    logic [TAG_W_D-1:0]    tag;
    logic [8*NBYTES_D-1:0] payload;
    logic                  par;
  } struct_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } packer_state_e;

  // Zero-extension leaves the XOR unchanged, so any width up to ParMaxW works.
  function automatic logic calc_par(input logic [ParMaxW-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/struct_member_byte_writer.sv
// Combinational indexed part-select insert: payload_o = payload_i with byte
// lane idx_i replaced by byte_i.
//   payload_i : current payload (8*NBYTES bits)
//   idx_i     : byte lane to overwrite
//   byte_i    : byte to insert
//   payload_o : updated payload
module struct_member_byte_writer #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [8*NBYTES-1:0] payload_i,
  input  logic [IdxW-1:0]     idx_i,
  input  logic [7:0]          byte_i,
  output logic [8*NBYTES-1:0] payload_o
);

  // Lane decode keeps every part-select constant, so an idx_i beyond the last
  // lane (unreachable by construction) writes nothing instead of going out of range.
  always_comb begin
    payload_o = payload_i;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_i == IdxW'(i)) begin
        payload_o[8*i +: 8] = byte_i;
      end
    end
  end

endmodule

// File: rtl/struct_member_packer.sv
// Byte-stream to packed-struct writer. Each accepted byte lands in
// payload[8*idx +: 8]; the tag comes from the first byte of a frame. A finished
// {tag, payload, par} word is held in a single-entry valid/ready buffer.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : byte-stream handshake (in_byte, in_tag, in_last)
//   out_valid/out_ready : word handshake (out_word, out_len)
// Build option: STRUCT_MEMBER_PACKER_PARITY_EN selects even parity in par;
// otherwise par is 1'b0.
module struct_member_packer
  import struct_member_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned TAG_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_byte,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TAG_W+8*NBYTES:0]   out_word,
  output logic [$clog2(NBYTES+1)-1:0] out_len
);

  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned LenW = $clog2(NBYTES + 1);
  localparam int unsigned PayW = 8 * NBYTES;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PayW-1:0]  payload;
    logic             par;
  } word_t;

  packer_state_e    state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [PayW-1:0]  payload_q, payload_d;
  word_t            word_q, word_d;
  logic [LenW-1:0]  len_q, len_d;

  logic             accept;
  logic             complete;
  logic             par;
  logic [IdxW-1:0]  wr_idx;
  logic [TAG_W-1:0] frame_tag;
  logic [PayW-1:0]  base_payload;
  logic [PayW-1:0]  wr_payload;

  assign in_ready  = rst_n && (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_word  = word_q;
  assign out_len   = len_q;
  assign accept    = in_valid && in_ready;

  // The first byte of a frame starts from a zero payload at lane 0 with the live tag.
  assign base_payload = (state_q == IDLE) ? '0 : payload_q;
  assign wr_idx       = (state_q == IDLE) ? '0 : idx_q;
  assign frame_tag    = (state_q == IDLE) ? in_tag : tag_q;
  assign complete     = in_last || (wr_idx == IdxW'(NBYTES - 1));

  struct_member_byte_writer #(
    .NBYTES (NBYTES),
    .IdxW   (IdxW)
  ) u_byte_writer (
    .payload_i (base_payload),
    .idx_i     (wr_idx),
    .byte_i    (in_byte),
    .payload_o (wr_payload)
  );

`ifdef STRUCT_MEMBER_PACKER_PARITY_EN
  assign par = calc_par(ParMaxW'({frame_tag, wr_payload}));
`else
  assign par = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    payload_d = payload_q;
    word_d    = word_q;
    len_d     = len_q;
    unique case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          payload_d = wr_payload;
          tag_d     = frame_tag;
          if (complete) begin
            state_d        = HOLD;
            idx_d          = '0;
            word_d.tag     = frame_tag;
            word_d.payload = wr_payload;
            word_d.par     = par;
            len_d          = LenW'(wr_idx) + LenW'(1);
          end else begin
            state_d = FILL;
            idx_d   = wr_idx + IdxW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tag_q     <= '0;
      payload_q <= '0;
      word_q    <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      payload_q <= payload_d;
      word_q    <= word_d;
      len_q     <= len_d;
    end
  end

endmodule
